// File: rtl/periph_bus_ctrl_if.sv
// CPU load/store and peripheral-slot signals of periph_bus_ctrl.
// master = the controller, slave = CPU, slots and read mux.
interface periph_bus_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic              done;
  logic [WIDTH-1:0]  rdata;
  logic              err;
  logic [4:0]        sel;
  logic              pwe;
  logic [ADDR_W-1:0] paddr;
  logic [WIDTH-1:0]  pwdata;
  logic [4:0]        pready;
  logic [2:0]        rdsel;
  logic [WIDTH-1:0]  readData;

  modport master (
    input  req, we, addr, wdata, pready, readData,
    output done, rdata, err, sel, pwe, paddr, pwdata, rdsel
  );

  modport slave (
    output req, we, addr, wdata, pready, readData,
    input  done, rdata, err, sel, pwe, paddr, pwdata, rdsel
  );
endinterface

// File: rtl/periph_bus_ctrl.sv
// Bus transaction controller: CPU request -> one of five peripheral slots -> one registered response.
// Optional ACCESS watchdog enabled by defining BUS_TIMEOUT_EN.
module periph_bus_ctrl #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int DEC_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  periph_bus_ctrl_if.master bus
);

  // state  | meaning
  // IDLE   | waiting for req; decode slot field
  // ACCESS | slot selected, waiting for its pready
  // RESP   | done pulse with registered rdata/err
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("periph_bus_ctrl: TIMEOUT must be at least 2");
  end

  state_t            state_q, state_d;
  logic [4:0]        sel_q, sel_d;
  logic              pwe_q, pwe_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic [2:0]        rdsel_q, rdsel_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [3:0]        field;
  logic              slot_ready;

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

  assign field      = bus.addr[DEC_LSB+3:DEC_LSB];
  // sel_q is one-hot on the active slot, so this observes only pready[i]
  assign slot_ready = |(bus.pready & sel_q);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    pwe_d    = pwe_q;
    done_d   = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    rdsel_d  = rdsel_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
`ifdef BUS_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        sel_d = 5'b0;
        pwe_d = 1'b0;
        if (bus.req) begin
          paddr_d  = bus.addr;
          pwdata_d = bus.wdata;
          if (field < 4'd5) begin
            rdsel_d = field[2:0];
            sel_d   = 5'b00001 << field[2:0];
            pwe_d   = bus.we;
`ifdef BUS_TIMEOUT_EN
            tmo_d   = TMO_W'(TIMEOUT - 1);
`endif
            state_d = ACCESS;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            done_d  = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        if (slot_ready) begin
          rdata_d = pwe_q ? '0 : bus.readData;
          err_d   = 1'b0;
          done_d  = 1'b1;
          sel_d   = 5'b0;
          pwe_d   = 1'b0;
          state_d = RESP;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_q == '0) begin
          rdata_d = '0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          sel_d   = 5'b0;
          pwe_d   = 1'b0;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
`endif
      end
      RESP: begin
        sel_d   = 5'b0;
        pwe_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        sel_d   = 5'b0;
        pwe_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 5'b0;
      pwe_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rdsel_q  <= 3'd0;
      paddr_q  <= '0;
      pwdata_q <= '0;
`ifdef BUS_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      pwe_q    <= pwe_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rdsel_q  <= rdsel_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
`ifdef BUS_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign bus.sel    = sel_q;
  assign bus.pwe    = pwe_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;
  assign bus.rdsel  = rdsel_q;
  assign bus.paddr  = paddr_q;
  assign bus.pwdata = pwdata_q;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Self-checking bench for periph_bus_ctrl: directed vector table, reset and back-to-back
// sequences, then randomized transactions against a transaction-level reference model.
module tb_periph_bus_ctrl;
  localparam int W   = 32;
  localparam int AW  = 32;
  localparam int TMO = 4;
`ifdef BUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    int          dly;
    int          lat;
    int          acc;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  periph_bus_ctrl_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

  periph_bus_ctrl #(.WIDTH(W), .ADDR_W(AW), .DEC_LSB(12), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] slot_data [5];
  always_comb bus.readData = (bus.rdsel < 3'd5) ? slot_data[bus.rdsel] : 32'h0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: one transaction's outcome from the slot field, direction and ready delay.
  function automatic void model(input logic [31:0] a, input bit w, input int dly,
                                output int lat, output int acc, output bit e,
                                output logic [31:0] rd);
    int f;
    f = int'(a[15:12]);
    if (f > 4) begin
      lat = 1; acc = 0; e = 1'b1; rd = 32'h0;
    end else if (TMO_EN && dly >= TMO) begin
      lat = TMO + 1; acc = TMO; e = 1'b1; rd = 32'h0;
    end else begin
      lat = dly + 2; acc = dly + 1; e = 1'b0;
      rd = w ? 32'h0 : slot_data[f];
    end
  endfunction

  task automatic run_txn(input logic [31:0] a, input bit w, input logic [31:0] wd,
                         input int dly, input logic [4:0] noise, input bit from_resp,
                         input bit hold, input int exp_lat, input bit exp_err,
                         input logic [31:0] exp_rd, input int exp_acc, input string tag);
    int n, ac, f;
    bit seen;
    logic [4:0] oh;
    n = 0; ac = 0; seen = 1'b0;
    f = int'(a[15:12]);
    oh = (f < 5) ? 5'(1 << f) : 5'b0;
    bus.req = 1'b1; bus.addr = a; bus.we = w; bus.wdata = wd;
    bus.pready = noise & ~oh;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) begin
        seen = 1'b1;
        last_done_cyc = cyc;
        if (!hold) bus.req = 1'b0;
        chk({tag, " resp_sel"}, 32'(bus.sel), 32'h0);
        chk({tag, " resp_pwe"}, 32'(bus.pwe), 32'h0);
        chk({tag, " latency"}, 32'(n), 32'(exp_lat + int'(from_resp)));
        chk({tag, " access_cycles"}, 32'(ac), 32'(exp_acc));
        chk({tag, " err"}, 32'(bus.err), 32'(exp_err));
        chk({tag, " rdata"}, bus.rdata, exp_rd);
      end else if (bus.sel != 5'b0) begin
        ac++;
        chk({tag, " sel"}, 32'(bus.sel), 32'(oh));
        chk({tag, " pwe"}, 32'(bus.pwe), 32'(w));
        chk({tag, " paddr"}, bus.paddr, a);
        chk({tag, " pwdata"}, bus.pwdata, wd);
        chk({tag, " rdsel"}, 32'(bus.rdsel), 32'(f));
        bus.pready = ((ac >= dly + 1) ? oh : 5'b0) | (noise & ~oh);
      end else begin
        chk({tag, " idle_pwe"}, 32'(bus.pwe), 32'h0);
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s no_done: got no done in 200 cycles, expected done", tag);
      bus.req = 1'b0;
    end
  endtask

  task automatic done_low(input string tag);
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, 32'(bus.done), 32'h0);
  endtask

  initial begin
    int lat, acc, d1, f, dly;
    bit e, w, hold, from_resp;
    logic [31:0] rd, a, wd;
    logic [4:0] noise;

    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.pready = '0;
    slot_data[0] = 32'h0A0A_0000; slot_data[1] = 32'h1111_1111; slot_data[2] = 32'hCAFE_F00D;
    slot_data[3] = 32'h3333_3333; slot_data[4] = 32'h4444_4444;

    vecs[0] = '{32'h0000_2010, 1'b0, 32'h0,         3, 5, 4, 1'b0, 32'hCAFE_F00D};
    vecs[1] = '{32'h0000_0004, 1'b1, 32'h1234_5678, 0, 2, 1, 1'b0, 32'h0};
    vecs[2] = '{32'h0000_7000, 1'b0, 32'h0,         0, 1, 0, 1'b1, 32'h0};
`ifdef BUS_TIMEOUT_EN
    vecs[3] = '{32'h0000_1000, 1'b0, 32'h0,         5, 5, 4, 1'b1, 32'h0};
`else
    vecs[3] = '{32'h0000_1000, 1'b0, 32'h0,         5, 7, 6, 1'b0, 32'h1111_1111};
`endif
    vecs[4] = '{32'hABCD_5123, 1'b1, 32'hAAAA_5555, 0, 1, 0, 1'b1, 32'h0};
    vecs[5] = '{32'h0000_3008, 1'b1, 32'h0F0F_0F0F, 3, 5, 4, 1'b0, 32'h0};
    vecs[6] = '{32'hFFFF_4FFC, 1'b0, 32'h0,         1, 3, 2, 1'b0, 32'h4444_4444};

    repeat (3) @(posedge clk);
    #1;
    chk("reset done", 32'(bus.done), 32'h0);
    chk("reset sel", 32'(bus.sel), 32'h0);
    chk("reset pwe", 32'(bus.pwe), 32'h0);
    chk("reset err", 32'(bus.err), 32'h0);
    chk("reset rdata", bus.rdata, 32'h0);
    chk("reset rdsel", 32'(bus.rdsel), 32'h0);
    chk("reset paddr", bus.paddr, 32'h0);
    chk("reset pwdata", bus.pwdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].dly, 5'b11111, 1'b0, 1'b0,
              vecs[i].lat, vecs[i].err, vecs[i].rd, vecs[i].acc, $sformatf("vec%0d", i));
      done_low($sformatf("vec%0d", i));
    end

    // reset while slot 3 is in ACCESS: transaction dropped, everything back to zero
    bus.req = 1'b1; bus.addr = 32'h0000_3000; bus.we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    bus.pready = 5'b0;
    @(posedge clk); #1;
    chk("midrst sel_before", 32'(bus.sel), 32'h0000_0008);
    @(posedge clk); #1;
    rst = 1'b1; bus.req = 1'b0;
    @(posedge clk); #1;
    chk("midrst done", 32'(bus.done), 32'h0);
    chk("midrst sel", 32'(bus.sel), 32'h0);
    chk("midrst pwe", 32'(bus.pwe), 32'h0);
    chk("midrst rdata", bus.rdata, 32'h0);
    chk("midrst rdsel", 32'(bus.rdsel), 32'h0);
    chk("midrst paddr", bus.paddr, 32'h0);
    chk("midrst pwdata", bus.pwdata, 32'h0);
    rst = 1'b0;
    run_txn(32'h0000_4000, 1'b0, 32'h0, 1, 5'b0, 1'b0, 1'b0, 3, 1'b0, 32'h4444_4444, 2, "after_rst");
    done_low("after_rst");

    // back-to-back: req held through done, next request sampled in the following IDLE
    run_txn(32'h0000_1000, 1'b0, 32'h0, 0, 5'b0, 1'b0, 1'b1, 2, 1'b0, 32'h1111_1111, 1, "b2b_a");
    d1 = last_done_cyc;
    run_txn(32'h0000_3000, 1'b0, 32'h0, 0, 5'b0, 1'b1, 1'b0, 2, 1'b0, 32'h3333_3333, 1, "b2b_b");
    chk("b2b done_gap", 32'(last_done_cyc - d1), 32'd3);
    done_low("b2b_b");

    from_resp = 1'b0;
    for (int k = 0; k < 60; k++) begin
      for (int s = 0; s < 5; s++) slot_data[s] = $urandom;
      f = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) f = f % 5;
      a = $urandom;
      a[15:12] = 4'(f);
      w = 1'($urandom_range(0, 1));
      wd = $urandom;
      dly = int'($urandom_range(0, 6));
      noise = 5'($urandom);
      hold = (k != 59) && ($urandom_range(0, 3) == 0);
      model(a, w, dly, lat, acc, e, rd);
      run_txn(a, w, wd, dly, noise, from_resp, hold, lat, e, rd, acc, $sformatf("rnd%0d", k));
      if (!hold) done_low($sformatf("rnd%0d", k));
      from_resp = hold;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
